// File: rtl/vpipe_pkg.sv
`default_nettype none
// ============================================================
// vpipe_pkg : opcodes, instruction field slices, ID/EX latch type
// Revision  : 1.0
// ============================================================
package vpipe_pkg;

  localparam int XLEN = 8;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_LI  = 2'b11;

  localparam int OP_HI  = 7;
  localparam int OP_LO  = 6;
  localparam int RS1_HI = 5;
  localparam int RS1_LO = 4;
  localparam int RS2_HI = 3;
  localparam int RS2_LO = 2;
  localparam int RD_HI  = 1;
  localparam int RD_LO  = 0;
  // LI reuses the rs1/rs2 fields as a 4-bit immediate
  localparam int IMM_HI = 5;
  localparam int IMM_LO = 2;

endpackage
`default_nettype wire

// File: rtl/vpipe_alu.sv
`default_nettype none
// ============================================================
// vpipe_alu : combinational ADD / SUB / LI datapath (mod 2^XLEN)
// Revision  : 1.0
// ============================================================
module vpipe_alu
  import vpipe_pkg::*;
#(
  parameter int XLEN = 8
) (
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      imm4,
  output logic [XLEN-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_LI:   result = {{(XLEN-4){1'b0}}, imm4};
      default: result = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/vpipe_core.sv
`default_nettype none
// ============================================================
// vpipe_core : 3-stage in-order pipeline (ID, EX, WB), full forwarding
// Revision   : 1.0
// ============================================================
module vpipe_core
  import vpipe_pkg::*;
#(
  parameter int NREG = 4,
  parameter int XLEN = 8,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_valid,
  input  logic [7:0]      inst,
  input  logic [1:0]      rf_rd_sel,
  output logic [XLEN-1:0] rf_rd_data,
  output logic [XLEN-1:0] ex_alu_result,
  output logic [XLEN-1:0] ex_wb_val,
  output logic            retire_valid,
  output logic [1:0]      retire_rd,
  output logic [XLEN-1:0] retire_data,
  output logic [CNTW-1:0] retire_cnt
);

  logic [XLEN-1:0] rf [NREG];

  logic            id_ex_valid;
  logic [1:0]      id_ex_op;
  logic [1:0]      id_ex_rd;
  logic [XLEN-1:0] id_ex_a;
  logic [XLEN-1:0] id_ex_b;
  logic [3:0]      id_ex_imm;

  logic            ex_wb_valid;
  logic [1:0]      ex_wb_rd;

  logic [XLEN-1:0] alu_out;
  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;

  logic [1:0] dec_op;
  logic [1:0] dec_rs1;
  logic [1:0] dec_rs2;
  logic [1:0] dec_rd;
  logic [3:0] dec_imm;
  logic       issue;

  assign dec_op  = inst[OP_HI:OP_LO];
  assign dec_rs1 = inst[RS1_HI:RS1_LO];
  assign dec_rs2 = inst[RS2_HI:RS2_LO];
  assign dec_rd  = inst[RD_HI:RD_LO];
  assign dec_imm = inst[IMM_HI:IMM_LO];
  assign issue   = inst_valid && (dec_op != OP_NOP);

  vpipe_alu #(.XLEN(XLEN)) u_alu (
    .op     (id_ex_op),
    .a      (id_ex_a),
    .b      (id_ex_b),
    .imm4   (id_ex_imm),
    .result (alu_out)
  );

  assign ex_alu_result = id_ex_valid ? alu_out : '0;

  // EX result is younger than WB, so it takes priority when both match
  always_comb begin
    fwd_a = rf[dec_rs1];
    if (ex_wb_valid && (ex_wb_rd == dec_rs1)) fwd_a = ex_wb_val;
    if (id_ex_valid && (id_ex_rd == dec_rs1)) fwd_a = ex_alu_result;
    fwd_b = rf[dec_rs2];
    if (ex_wb_valid && (ex_wb_rd == dec_rs2)) fwd_b = ex_wb_val;
    if (id_ex_valid && (id_ex_rd == dec_rs2)) fwd_b = ex_alu_result;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
      id_ex_valid <= 1'b0;
      id_ex_op    <= OP_NOP;
      id_ex_rd    <= '0;
      id_ex_a     <= '0;
      id_ex_b     <= '0;
      id_ex_imm   <= '0;
      ex_wb_valid <= 1'b0;
      ex_wb_rd    <= '0;
      ex_wb_val   <= '0;
      retire_cnt  <= '0;
    end else begin
      id_ex_valid <= issue;
      id_ex_op    <= dec_op;
      id_ex_rd    <= dec_rd;
      id_ex_a     <= fwd_a;
      id_ex_b     <= fwd_b;
      id_ex_imm   <= dec_imm;

      ex_wb_valid <= id_ex_valid;
      ex_wb_rd    <= id_ex_rd;
      ex_wb_val   <= ex_alu_result;

      if (ex_wb_valid) begin
        rf[ex_wb_rd] <= ex_wb_val;
        retire_cnt   <= retire_cnt + CNTW'(1);
      end
    end
  end

  assign rf_rd_data   = rf[rf_rd_sel];
  assign retire_valid = ex_wb_valid;
  assign retire_rd    = ex_wb_rd;
  assign retire_data  = ex_wb_val;

endmodule
`default_nettype wire

// File: tb/tb_vpipe_core.sv
`default_nettype none
// ============================================================
// tb_vpipe_core : directed + random stimulus against a sequential ISA model
// Revision      : 1.0
// ============================================================
module tb_vpipe_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid;
  logic [7:0]  inst;
  logic [1:0]  rf_rd_sel;
  logic [7:0]  rf_rd_data;
  logic [7:0]  ex_alu_result;
  logic [7:0]  ex_wb_val;
  logic        retire_valid;
  logic [1:0]  retire_rd;
  logic [7:0]  retire_data;
  logic [15:0] retire_cnt;

  int vectors     = 0;
  int miscompares = 0;
  logic check_en  = 1'b0;

  always #5 clk = ~clk;

  vpipe_core #(.NREG(4), .XLEN(8), .CNTW(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .rf_rd_sel     (rf_rd_sel),
    .rf_rd_data    (rf_rd_data),
    .ex_alu_result (ex_alu_result),
    .ex_wb_val     (ex_wb_val),
    .retire_valid  (retire_valid),
    .retire_rd     (retire_rd),
    .retire_data   (retire_data),
    .retire_cnt    (retire_cnt)
  );

  // Model: arch[] holds sequential ISA state as of the last issue; results
  // then travel one slot per edge into EX, WB, and finally the visible rf.
  logic [7:0]  arch [4] = '{default: 8'h00};
  logic [7:0]  vis  [4] = '{default: 8'h00};
  logic        m_ex_v = 1'b0, m_wb_v = 1'b0;
  logic [1:0]  m_ex_rd = 2'd0, m_wb_rd = 2'd0;
  logic [7:0]  m_ex_res = 8'h00, m_wb_res = 8'h00;
  logic [15:0] m_cnt = 16'h0000;

  always @(posedge clk) begin
    logic [7:0] a, b, r;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin arch[i] = 8'h00; vis[i] = 8'h00; end
      m_ex_v = 1'b0; m_ex_res = 8'h00; m_ex_rd = 2'd0;
      m_wb_v = 1'b0; m_wb_res = 8'h00; m_wb_rd = 2'd0;
      m_cnt  = 16'h0000;
    end else begin
      if (m_wb_v) begin
        vis[m_wb_rd] = m_wb_res;
        m_cnt        = m_cnt + 16'd1;
      end
      m_wb_v = m_ex_v; m_wb_rd = m_ex_rd; m_wb_res = m_ex_res;
      if (inst_valid && inst[7:6] != 2'b00) begin
        a = arch[inst[5:4]];
        b = arch[inst[3:2]];
        case (inst[7:6])
          2'b01:   r = a + b;
          2'b10:   r = a - b;
          default: r = {4'h0, inst[5:2]};
        endcase
        arch[inst[1:0]] = r;
        m_ex_v = 1'b1; m_ex_rd = inst[1:0]; m_ex_res = r;
      end else begin
        m_ex_v = 1'b0; m_ex_res = 8'h00;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("ex_alu_result", 32'(ex_alu_result), 32'(m_ex_res));
      chk("ex_wb_val", 32'(ex_wb_val), 32'(m_wb_res));
      chk("retire_valid", 32'(retire_valid), 32'(m_wb_v));
      if (m_wb_v) begin
        chk("retire_rd", 32'(retire_rd), 32'(m_wb_rd));
        chk("retire_data", 32'(retire_data), 32'(m_wb_res));
      end
      chk("retire_cnt", 32'(retire_cnt), 32'(m_cnt));
      chk("rf_rd_data", 32'(rf_rd_data), 32'(vis[rf_rd_sel]));
    end
  end

  function automatic logic [7:0] enc(input logic [1:0] op, input logic [1:0] rs1,
                                     input logic [1:0] rs2, input logic [1:0] rd);
    return {op, rs1, rs2, rd};
  endfunction

  function automatic logic [7:0] li(input logic [3:0] imm, input logic [1:0] rd);
    return {2'b11, imm, rd};
  endfunction

  task automatic issue(input logic v, input logic [7:0] ins);
    inst_valid = v;
    inst       = ins;
    rf_rd_sel  = 2'($urandom_range(0, 3));
    @(posedge clk);
    #1;
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) issue(1'b0, 8'h00);
  endtask

  task automatic peek(input string nm, input logic [1:0] sel, input logic [7:0] exp);
    rf_rd_sel = sel;
    #1;
    chk(nm, 32'(rf_rd_data), 32'(exp));
  endtask

  initial begin
    rst = 1'b1; inst_valid = 1'b0; inst = 8'h00; rf_rd_sel = 2'd0;
    @(posedge clk); #1;
    check_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // reset then idle: nothing retires, rf stays zero
    for (int i = 0; i < 10; i++) issue(1'b1, 8'h00);
    for (int s = 0; s < 4; s++) peek("reset_rf", 2'(s), 8'h00);
    chk("reset_cnt", 32'(retire_cnt), 32'd0);

    // LI r1,5 ; LI r2,3 ; ADD r3=r1+r2
    issue(1'b1, li(4'd5, 2'd1));
    issue(1'b1, li(4'd3, 2'd2));
    issue(1'b1, enc(2'b01, 2'd1, 2'd2, 2'd3));
    chk("add_ex_fwd", 32'(ex_alu_result), 32'h08);
    nops(2);
    peek("rf3_add", 2'd3, 8'h08);
    chk("cnt_after_3", 32'(retire_cnt), 32'd3);

    // SUB r0=r2-r1 wraps; ADD r0=r0+r0 forwards it
    issue(1'b1, enc(2'b10, 2'd2, 2'd1, 2'd0));
    chk("sub_wrap_ex", 32'(ex_alu_result), 32'hFE);
    issue(1'b1, enc(2'b01, 2'd0, 2'd0, 2'd0));
    chk("add_r0_ex", 32'(ex_alu_result), 32'hFC);
    nops(2);
    peek("rf0_fc", 2'd0, 8'hFC);
    chk("cnt_after_5", 32'(retire_cnt), 32'd5);

    // younger write wins, EX forward beats WB forward
    issue(1'b1, li(4'd15, 2'd1));
    issue(1'b1, li(4'd2, 2'd1));
    issue(1'b1, enc(2'b01, 2'd1, 2'd1, 2'd2));
    nops(2);
    peek("rf1_young", 2'd1, 8'h02);
    peek("rf2_fwd", 2'd2, 8'h04);

    // reset with an instruction in flight and one presented during reset
    issue(1'b1, li(4'd9, 2'd3));
    rst = 1'b1;
    issue(1'b1, li(4'd7, 2'd0));
    rst = 1'b0;
    nops(3);
    peek("rst_rf3", 2'd3, 8'h00);
    peek("rst_rf0", 2'd0, 8'h00);
    chk("rst_cnt", 32'(retire_cnt), 32'd0);

    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      issue(1'($urandom_range(0, 7) != 0), 8'($urandom));
    end
    rst = 1'b0;
    nops(3);

    // counter wrap
    rst = 1'b1;
    nops(1);
    rst = 1'b0;
    for (int i = 0; i < 65535; i++) issue(1'b1, li(4'($urandom), 2'($urandom)));
    nops(1);
    issue(1'b1, 8'h00);
    issue(1'b0, 8'hC5);
    chk("cnt_ffff", 32'(retire_cnt), 32'hFFFF);
    issue(1'b1, li(4'd1, 2'd0));
    nops(2);
    chk("cnt_wrap", 32'(retire_cnt), 32'h0000);

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vpipe_core.md
# vpipe_core

Three-stage 8-bit, four-register in-order pipeline: decode/read, execute, writeback. It is the implementation side of the vpipe refinement flow. It accepts one instruction per cycle with no stalls, using full forwarding. It exposes the EX-stage result, the WB-stage value, a register-file read port and a per-instruction retire pulse, so the verification wrapper can align architectural state against the ILA model.

## Interface
Parameters:
- NREG, 4, number of architectural registers (index width 2; fixed by encoding)
- XLEN, 8, data width
- CNTW, 16, retire counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- inst_valid  in  1  instruction on inst is issued this cycle
- inst  in  8  instruction: [7:6] op, [5:4] rs1, [3:2] rs2, [1:0] rd
- rf_rd_sel  in  2  register-file debug read select
- rf_rd_data  out  8  rf[rf_rd_sel], combinational, no forwarding
- ex_alu_result  out  8  combinational ALU output of the instruction in EX (0 when EX is empty)
- ex_wb_val  out  8  registered value held in the EX/WB latch
- retire_valid  out  1  an instruction completes writeback at the next edge
- retire_rd  out  2  destination of the retiring instruction
- retire_data  out  8  value being written
- retire_cnt  out  16  number of retired non-NOP instructions, wraps modulo 2^16

## Operation
- Opcodes:
  - 00 NOP: no write, never retires.
  - 01 ADD: rd = rs1 + rs2.
  - 10 SUB: rd = rs1 − rs2.
  - 11 LI: rd = {4'b0, inst[5:2]}, where rs1/rs2 fields form the immediate.
- Arithmetic is modulo 256; carries and borrows are discarded.
- ID (edge k): an instruction with inst_valid=1 and op≠NOP sets id_ex_valid and latches op, rd and both operands. NOP or inst_valid=0 clears id_ex_valid.
- Operand select, in priority order:
  1. EX forward: id_ex_valid and id_ex_rd==rsX gives ex_alu_result.
  2. WB forward: ex_wb_valid and ex_wb_rd==rsX gives ex_wb_val.
  3. Otherwise rf[rsX].
- EX: ex_alu_result is computed combinationally from the id_ex latch. At edge k+1 the block latches ex_wb_valid, ex_wb_rd and ex_wb_val from it.
- WB: when ex_wb_valid is set, edge k+2 writes rf[ex_wb_rd] and increments retire_cnt.
- retire_valid equals ex_wb_valid; retire_rd and retire_data are the ex_wb latch contents.
- rf_rd_data reads the register file only: a value becomes visible in the cycle after edge k+2.
- Same-rd writes from consecutive instructions: the younger write wins, because writes are in order.
- An instruction with rs==rd reads the old value.

## Timing
- Reset values:
  - rf all 0x00
  - id_ex_valid and ex_wb_valid 0
  - ex_wb_val 0x00
  - ex_alu_result 0x00
  - retire_valid 0, retire_rd 0, retire_data 0x00
  - retire_cnt 0
- Latencies:
  - Issue at edge k: retire_valid is high in the cycle between edges k+1 and k+2.
  - rf is updated at edge k+2.
  - Result is forwardable to an instruction issued at edge k+1 (via EX) or at edge k+2 (via WB).
- Throughput is one instruction per cycle. There is no back-pressure and no inst_ready.
- Reset mid-operation: all in-flight instructions are dropped, with no rf write and no retire pulse. An instruction presented in the reset cycle is ignored. State matches the reset values on the first cycle after rst deasserts.
- retire_cnt wraps from 0xFFFF to 0x0000 without any flag.

## Structure
- Package vpipe_pkg holds:
  - opcode localparams: OP_NOP, OP_ADD, OP_SUB, OP_LI;
  - field-slice constants for op, rs1, rs2 and rd;
  - XLEN.
- Sub-module vpipe_alu: combinational, with inputs op, a, b and imm4, and output result.
- Top level holds the register file, the two pipeline latches, forwarding muxes and the retire counter.

## Test plan
- Reset: after rst, then 10 cycles of NOP → rf_rd_data=0 for every sel, retire_valid never high, retire_cnt=0.
- LI r1,5 then LI r2,3 then ADD r3=r1+r2, back-to-back → retire sequence (1,0x05), (2,0x03), (3,0x08); rf[3]=0x08; retire_cnt=3. This exercises EX and WB forwarding.
- From the previous state, SUB r0=r2−r1 → ex_alu_result=0xFE in EX cycle, rf[0]=0xFE (wrap). ADD r0=r0+r0 immediately after → 0xFC.
- LI r1,15 then LI r1,2 then ADD r2=r1+r1 → r1=0x02, r2=0x04. Confirms younger write and EX-forward priority over WB.
- Issue LI r3,9, assert rst the next cycle → rf[3]=0, no retire pulse, retire_cnt=0.
- Force retire_cnt to 0xFFFF via 65535 LI ops, then one more → retire_cnt=0x0000. NOP and inst_valid=0 cycles do not count.
